memory_cycle: RTL and testbench
===============================

# memory_cycle

Memory-access (M) stage of the 19-bit pipelined CPU. It sits between the execute stage and `write_back_cycle`. It performs the data-memory load or store for the instruction in M. It also holds the M/W pipeline register that drives `aluresultW`, `readdataW`, `resultsrcW`, `regwriteW` and `rdW` into write-back. Stall and flush inputs from the hazard unit control that register.

## Interface
- `DATA_W`, 19, datapath width; must match `write_back_cycle`.
- `MEM_AW`, 8, data-memory address width (depth = 2^MEM_AW words of DATA_W bits).
- `RD_W`, 4, destination-register index width.

- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `aluresultM`  in  DATA_W  ALU result; the memory address for loads and stores.
- `writedataM`  in  DATA_W  store data.
- `memwriteM`  in  1  store enable.
- `resultsrcM`  in  1  1 = result comes from memory (load), 0 = result comes from ALU.
- `regwriteM`  in  1  instruction writes the register file.
- `rdM`  in  RD_W  destination register.
- `stallW`  in  1  hold the M/W register; suppress the store.
- `flushW`  in  1  kill the M instruction; load a bubble into M/W.
- `aluresultW`  out  DATA_W  registered ALU result.
- `readdataW`  out  DATA_W  registered load data.
- `resultsrcW`  out  1  registered result select.
- `regwriteW`  out  1  registered register-write enable.
- `rdW`  out  RD_W  registered destination register.

## Operation
- Address = `aluresultM[MEM_AW-1:0]`. Upper bits are ignored, so addresses wrap modulo depth. No fault is raised.
- Read: combinational, `rdata = mem[addr]`. It is read every cycle regardless of `resultsrcM`.
- Write: `mem[addr] <= writedataM` at the clock edge when `memwriteM & ~stallW & ~flushW & ~rst`.
- Memory contents are not reset. Contents are undefined until written.
- M/W register update priority per edge: `rst` > `flushW` > `stallW` > load.
  - `rst`: all outputs go to 0.
  - `flushW`: all outputs go to 0, a bubble (`regwriteW=0` guarantees no architectural effect).
  - `stallW`: all outputs hold their value.
  - Otherwise the register loads `aluresultM`, `rdata`, `resultsrcM`, `regwriteM`, `rdM`.
- `flushW & stallW` together: flush wins. The store is suppressed and a bubble is loaded.
- A store and a load to the same address in the same cycle cannot occur (one instruction per stage). A store in cycle N followed by a load of the same address in cycle N+1 returns the new data.
- `memwriteM` and `resultsrcM` both set is illegal upstream. If it happens, the store occurs, and `readdataW` captures the pre-store value.

## Timing
- Latency is 1 cycle from M inputs to W outputs.
- Load-to-result: `readdataW` is valid the cycle after the load is in M. `write_back_cycle` selects it combinationally in that same cycle.
- A store commits at the end of its M cycle and is visible to a combinational read from the next cycle onward.
- Reset takes effect at the first rising edge with `rst=1`. Outputs are all zero after that edge. No store occurs on that edge.
- Reset mid-stall clears the outputs; the stall does not hold them.
- No backpressure handshake. The stage always accepts unless `stallW` is set; upstream holds M inputs stable while stalled.

## Structure
- Shared package `cpu_pkg`: `DATA_W=19`, `RD_W` constant, and `RESULT_ALU=1'b0` / `RESULT_MEM=1'b1` encodings, shared with `write_back_cycle` and the execute stage.
- One sub-module, `data_memory`:
  - ports `clk`, `we`, `addr[MEM_AW-1:0]`, `wdata`, `rdata`;
  - synchronous write, asynchronous read;
  - no reset.
- `memory_cycle` instantiates `data_memory` and holds the M/W register and the write gating.

## Test plan
- Reset: drive `rst=1` for 2 cycles with `memwriteM=1`, `aluresultM=0x00005`, `writedataM=0x7FFFF` → all outputs 0; a later load of address 5 does not return 0x7FFFF.
- Store then load: store 0x12345 to address 0x10. Next cycle, load 0x10 with `resultsrcM=1`, `regwriteM=1`, `rdM=3` → one cycle later `readdataW=0x12345`, `resultsrcW=1`, `regwriteW=1`, `rdW=3`.
- ALU pass-through: `aluresultM=0x40001`, `resultsrcM=0`, `regwriteM=1`, `rdM=7` → next cycle `aluresultW=0x40001`, `resultsrcW=0`, `rdW=7`. Memory is unchanged.
- Address wrap (`MEM_AW=8`): store 0x00ABC at `aluresultM=0x00105`, then load `aluresultM=0x00005` → `readdataW=0x00ABC`.
- Stall: load registered, then `stallW=1` for 3 cycles with new inputs and `memwriteM=1` to address 0x20 → outputs frozen for 3 cycles. Address 0x20 is unwritten until the cycle `stallW` drops.
- Flush priority: `flushW=1`, `stallW=1`, `memwriteM=1` to address 0x30 with data 0x00001 → next cycle all outputs 0; a later load of 0x30 does not return 0x00001.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared constants and bundle types for the 19-bit pipelined CPU.
// Used by the execute, memory and write-back stages.
package cpu_pkg;

  localparam int DATA_W = 19;
  localparam int RD_W   = 4;
  localparam int MEM_AW = 8;

  localparam logic RESULT_ALU = 1'b0;
  localparam logic RESULT_MEM = 1'b1;

  typedef struct packed {
    logic [DATA_W-1:0] aluresult;
    logic [DATA_W-1:0] readdata;
    logic              resultsrc;
    logic              regwrite;
    logic [RD_W-1:0]   rd;
  } mem_wb_t;

  function automatic mem_wb_t mw_bubble();
    mem_wb_t b;
    b = '0;
    return b;
  endfunction

endpackage

// File: rtl/memory_cycle_if.sv
// M-stage inputs from execute and M/W outputs to write-back.
// Hazard controls travel with the bundle they act on.
interface memory_cycle_if;
  import cpu_pkg::*;

  logic [DATA_W-1:0] aluresultM;
  logic [DATA_W-1:0] writedataM;
  logic              memwriteM;
  logic              resultsrcM;
  logic              regwriteM;
  logic [RD_W-1:0]   rdM;
  logic              stallW;
  logic              flushW;

  logic [DATA_W-1:0] aluresultW;
  logic [DATA_W-1:0] readdataW;
  logic              resultsrcW;
  logic              regwriteW;
  logic [RD_W-1:0]   rdW;

  modport master (
    output aluresultM, writedataM, memwriteM,
    output resultsrcM, regwriteM, rdM,
    output stallW, flushW,
    input  aluresultW, readdataW, resultsrcW,
    input  regwriteW, rdW
  );

  modport slave (
    input  aluresultM, writedataM, memwriteM,
    input  resultsrcM, regwriteM, rdM,
    input  stallW, flushW,
    output aluresultW, readdataW, resultsrcW,
    output regwriteW, rdW
  );

endinterface

// File: rtl/data_memory.sv
// Data RAM: synchronous write, asynchronous read, no reset.
// Contents are undefined until written.
module data_memory #(
  parameter int DW = 19,
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/memory_cycle.sv
// Memory-access stage: data-memory load/store plus the M/W register.
// Priority on each edge is rst > flushW > stallW > load.
module memory_cycle
  import cpu_pkg::*;
(
  input logic          clk,
  input logic          rst,
  memory_cycle_if.slave m
);

  logic [MEM_AW-1:0] addr;
  logic [DATA_W-1:0] rdata;
  logic              we;

  mem_wb_t mw_d;
  mem_wb_t mw_q;

  assign addr = m.aluresultM[MEM_AW-1:0];

  // A killed or held instruction must not touch memory.
  always_comb begin
    we = m.memwriteM & ~m.stallW & ~m.flushW & ~rst;
  end

  data_memory #(
    .DW (DATA_W),
    .AW (MEM_AW)
  ) u_dmem (
    .clk   (clk),
    .we    (we),
    .addr  (addr),
    .wdata (m.writedataM),
    .rdata (rdata)
  );

  always_comb begin
    mw_d = mw_q;
    if (rst) begin
      mw_d = mw_bubble();
    end else if (m.flushW) begin
      mw_d = mw_bubble();
    end else if (!m.stallW) begin
      mw_d.aluresult = m.aluresultM;
      mw_d.readdata  = rdata;
      mw_d.resultsrc = m.resultsrcM;
      mw_d.regwrite  = m.regwriteM;
      mw_d.rd        = m.rdM;
    end
  end

  always_ff @(posedge clk) begin
    mw_q <= mw_d;
  end

  assign m.aluresultW = mw_q.aluresult;
  assign m.readdataW  = mw_q.readdata;
  assign m.resultsrcW = mw_q.resultsrc;
  assign m.regwriteW  = mw_q.regwrite;
  assign m.rdW        = mw_q.rd;

endmodule

// File: tb/tb_memory_cycle.sv
// Directed bench for memory_cycle.
// Inputs change #1 after the rising edge; outputs are checked there.
module tb_memory_cycle;
  import cpu_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   n_chk = 0;
  int   n_fail = 0;

  memory_cycle_if bus ();

  memory_cycle dut (
    .clk (clk),
    .rst (rst),
    .m   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  task automatic drive(input logic [DATA_W-1:0] alu,
                       input logic [DATA_W-1:0] wd,
                       input logic mw, input logic rs,
                       input logic rw, input logic [RD_W-1:0] rd);
    bus.aluresultM = alu;
    bus.writedataM = wd;
    bus.memwriteM  = mw;
    bus.resultsrcM = rs;
    bus.regwriteM  = rw;
    bus.rdM        = rd;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag,
                         input logic [DATA_W-1:0] alu,
                         input logic [DATA_W-1:0] rdat,
                         input logic rs, input logic rw,
                         input logic [RD_W-1:0] rd);
    chk({tag, ".alu"}, 32'(bus.aluresultW), 32'(alu));
    chk({tag, ".rdata"}, 32'(bus.readdataW), 32'(rdat));
    chk({tag, ".rsrc"}, 32'(bus.resultsrcW), 32'(rs));
    chk({tag, ".rwr"}, 32'(bus.regwriteW), 32'(rw));
    chk({tag, ".rd"}, 32'(bus.rdW), 32'(rd));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.stallW = 1'b0;
    bus.flushW = 1'b0;
    rst = 1'b1;
    drive(19'h00005, 19'h7FFFF, 1'b1, 1'b0, 1'b1, 4'd2);
    #1;
    tick();
    tick();
    chk_all("reset", '0, '0, 1'b0, 1'b0, '0);

    rst = 1'b0;
    drive(19'h00010, 19'h12345, 1'b1, 1'b0, 1'b0, 4'd0);
    tick();
    drive(19'h00010, 19'h00000, 1'b0, RESULT_MEM, 1'b1, 4'd3);
    tick();
    chk_all("st_ld", 19'h00010, 19'h12345, 1'b1, 1'b1, 4'd3);

    drive(19'h00005, 19'h00000, 1'b0, RESULT_MEM, 1'b1, 4'd4);
    tick();
    chk("rst_nostore", 32'(bus.readdataW != 19'h7FFFF), 32'd1);

    drive(19'h00001, 19'h11111, 1'b1, 1'b0, 1'b0, 4'd0);
    tick();
    drive(19'h40001, 19'h2AAAA, 1'b0, RESULT_ALU, 1'b1, 4'd7);
    tick();
    chk_all("alu", 19'h40001, 19'h11111, 1'b0, 1'b1, 4'd7);
    drive(19'h00001, 19'h00000, 1'b0, RESULT_MEM, 1'b1, 4'd1);
    tick();
    chk("alu_memkeep", 32'(bus.readdataW), 32'h11111);

    drive(19'h00105, 19'h00ABC, 1'b1, 1'b0, 1'b0, 4'd0);
    tick();
    drive(19'h00005, 19'h00000, 1'b0, RESULT_MEM, 1'b1, 4'd2);
    tick();
    chk("wrap", 32'(bus.readdataW), 32'h00ABC);

    drive(19'h00020, 19'h00777, 1'b1, 1'b0, 1'b0, 4'd0);
    tick();
    drive(19'h00010, 19'h00000, 1'b0, RESULT_MEM, 1'b1, 4'd3);
    tick();
    bus.stallW = 1'b1;
    drive(19'h00020, 19'h55555, 1'b1, RESULT_ALU, 1'b1, 4'd9);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_all($sformatf("stall%0d", i), 19'h00010,
              19'h12345, 1'b1, 1'b1, 4'd3);
    end
    bus.stallW = 1'b0;
    tick();
    chk_all("unstall", 19'h00020, 19'h00777, 1'b0, 1'b1, 4'd9);
    drive(19'h00020, 19'h00000, 1'b0, RESULT_MEM, 1'b1, 4'd6);
    tick();
    chk("stall_store", 32'(bus.readdataW), 32'h55555);

    drive(19'h00030, 19'h00002, 1'b1, 1'b0, 1'b0, 4'd0);
    tick();
    bus.flushW = 1'b1;
    bus.stallW = 1'b1;
    drive(19'h00030, 19'h00001, 1'b1, RESULT_MEM, 1'b1, 4'd5);
    tick();
    chk_all("flush", '0, '0, 1'b0, 1'b0, '0);
    bus.flushW = 1'b0;
    bus.stallW = 1'b0;
    drive(19'h00030, 19'h00000, 1'b0, RESULT_MEM, 1'b1, 4'd1);
    tick();
    chk("flush_nostore", 32'(bus.readdataW), 32'h00002);

    drive(19'h00040, 19'h00333, 1'b1, 1'b0, 1'b0, 4'd0);
    tick();
    drive(19'h00010, 19'h00000, 1'b0, RESULT_MEM, 1'b1, 4'd8);
    tick();
    rst = 1'b1;
    bus.stallW = 1'b1;
    drive(19'h00040, 19'h7ABCD, 1'b1, RESULT_MEM, 1'b1, 4'd8);
    tick();
    chk_all("rst_stall", '0, '0, 1'b0, 1'b0, '0);
    rst = 1'b0;
    bus.stallW = 1'b0;
    drive(19'h00040, 19'h00000, 1'b0, RESULT_MEM, 1'b1, 4'd2);
    tick();
    chk("rst_stall_mem", 32'(bus.readdataW), 32'h00333);

    drive(19'h00050, 19'h00444, 1'b1, 1'b0, 1'b0, 4'd0);
    tick();
    drive(19'h00050, 19'h00999, 1'b1, RESULT_MEM, 1'b1, 4'd4);
    tick();
    chk("both_pre", 32'(bus.readdataW), 32'h00444);
    drive(19'h00050, 19'h00000, 1'b0, RESULT_MEM, 1'b1, 4'd4);
    tick();
    chk("both_post", 32'(bus.readdataW), 32'h00999);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
